// File: rtl/sum_averager.sv
// Mean of NUM_INPUTS operands from their signed tree sum: a sequential restoring divide by the
// constant NUM_INPUTS, round half away from zero, then saturate to DATA_WIDTH.
module sum_averager #(
  parameter int unsigned NUM_INPUTS = 10,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IN_WIDTH   = DATA_WIDTH + $clog2(NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic [IN_WIDTH-1:0]   data_in,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  sat_out
);

  localparam int unsigned RemWidth = $clog2(NUM_INPUTS) + 1;
  localparam int unsigned CntWidth = $clog2(IN_WIDTH);

  localparam logic [RemWidth-1:0] Divisor = RemWidth'(NUM_INPUTS);
  // Magnitude limits at mean width: 2^(DW-1)-1 for positive results, 2^(DW-1) for negative.
  localparam logic [IN_WIDTH:0] PosLimit =
    {{(IN_WIDTH - DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic [IN_WIDTH:0] NegLimit = PosLimit + {{IN_WIDTH{1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] PosClamp = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] NegClamp = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

  if (NUM_INPUTS < 2) begin : gen_param_check
    $error("sum_averager: NUM_INPUTS must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StDiv, StRound, StHold} state_e;

  state_e                state_q, state_d;
  logic                  sign_q, sign_d;
  // Holds the dividend magnitude; quotient bits shift in at the LSB as dividend bits leave the MSB.
  logic [IN_WIDTH-1:0]   work_q, work_d;
  logic [RemWidth-1:0]   rem_q, rem_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  sat_q, sat_d;
  logic                  valid_q, valid_d;

  logic [IN_WIDTH-1:0]   abs_in;
  logic [RemWidth-1:0]   rem_shift;
  logic                  rem_ge;
  logic                  round_up;
  logic [IN_WIDTH:0]     mag;
  logic [DATA_WIDTH-1:0] mag_lo;
  logic                  neg;
  logic [DATA_WIDTH-1:0] result;
  logic                  result_sat;

  always_comb begin
    abs_in    = data_in[IN_WIDTH-1] ? (~data_in + {{(IN_WIDTH - 1){1'b0}}, 1'b1}) : data_in;
    rem_shift = {rem_q[RemWidth-2:0], work_q[IN_WIDTH-1]};
    rem_ge    = (rem_shift >= Divisor);
  end

  always_comb begin
    round_up = ({rem_q, 1'b0} >= {1'b0, Divisor});
    mag      = {1'b0, work_q} + {{IN_WIDTH{1'b0}}, round_up};
    mag_lo   = mag[DATA_WIDTH-1:0];
    // A zero magnitude is never reported as negative.
    neg      = sign_q && (mag != '0);
    result     = neg ? -mag_lo : mag_lo;
    result_sat = 1'b0;
    if (!neg && (mag > PosLimit)) begin
      result     = PosClamp;
      result_sat = 1'b1;
    end else if (neg && (mag > NegLimit)) begin
      result     = NegClamp;
      result_sat = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    work_d  = work_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    sat_d   = sat_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (valid_in) begin
          sign_d  = data_in[IN_WIDTH-1];
          work_d  = abs_in;
          rem_d   = '0;
          cnt_d   = CntWidth'(IN_WIDTH - 1);
          state_d = StDiv;
        end
      end
      StDiv: begin
        work_d = {work_q[IN_WIDTH-2:0], rem_ge};
        rem_d  = rem_ge ? (rem_shift - Divisor) : rem_shift;
        cnt_d  = cnt_q - CntWidth'(1);
        if (cnt_q == '0) begin
          state_d = StRound;
        end
      end
      StRound: begin
        data_d  = result;
        sat_d   = result_sat;
        valid_d = 1'b1;
        state_d = StHold;
      end
      StHold: begin
        if (ready_out) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sign_q  <= 1'b0;
      work_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
    end
  end

  assign ready_in  = (state_q == StIdle);
  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign sat_out   = sat_q;

endmodule

// File: tb/tb_sum_averager.sv
// Randomised self-checking bench for sum_averager (NUM_INPUTS=10, DATA_WIDTH=16) against an
// integer-arithmetic mean/round/saturate model.
module tb_sum_averager;

  localparam int N  = 10;
  localparam int DW = 16;
  localparam int IW = 20;
  localparam int Latency = IW + 1;

  logic          clk;
  logic          rst_n;
  logic          valid_in;
  logic          ready_in;
  logic [IW-1:0] data_in;
  logic          valid_out;
  logic          ready_out;
  logic [DW-1:0] data_out;
  logic          sat_out;

  int errors;
  int checks;

  sum_averager #(
    .NUM_INPUTS(N),
    .DATA_WIDTH(DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .ready_in (ready_in),
    .data_in  (data_in),
    .valid_out(valid_out),
    .ready_out(ready_out),
    .data_out (data_out),
    .sat_out  (sat_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  function automatic void model(input int s, output logic [DW-1:0] d, output logic sat);
    int a;
    int q;
    int r;
    int m;
    int res;
    a   = (s < 0) ? -s : s;
    q   = a / N;
    r   = a % N;
    m   = q + ((2 * r >= N) ? 1 : 0);
    res = (s < 0) ? -m : m;
    sat = 1'b0;
    if (res > 32767) begin
      res = 32767;
      sat = 1'b1;
    end else if (res < -32768) begin
      res = -32768;
      sat = 1'b1;
    end
    d = res[DW-1:0];
  endfunction

  // Issues one sum, returns the result, latency in edges after acceptance (-1 on timeout) and,
  // when ready_out is high, whether the handshake edge returned the block to idle.
  task automatic do_op(input int v, output logic [DW-1:0] d, output logic s, output int lat,
                       output logic hs_ok);
    int guard;
    guard    = 0;
    data_in  = v[IW-1:0];
    valid_in = 1'b1;
    while (!ready_in && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    lat = 0;
    while (lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (valid_out) break;
    end
    if (!valid_out) lat = -1;
    d     = data_out;
    s     = sat_out;
    hs_ok = 1'b1;
    if (ready_out) begin
      @(posedge clk); #1;
      hs_ok = ready_in && !valid_out;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    data_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ready_in, valid_out, data_out, sat_out} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: ready_in=%b valid_out=%b data_out=%h sat_out=%b, need 1 0 0000 0",
               ready_in, valid_out, data_out, sat_out);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready_in !== 1'b1 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready_in=%b valid_out=%b, need 1 0", ready_in, valid_out);
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] d;
    logic s;
    logic hs;
    int lat;
    do_op(100, d, s, lat, hs);
    checks++;
    if (d !== 16'd10 || s !== 1'b0) begin
      errors++;
      $display("FAIL basic_100: data=%0d sat=%b, need 10 0", $signed(d), s);
    end
    checks++;
    if (lat !== Latency) begin
      errors++;
      $display("FAIL basic_latency: %0d edges, need %0d", lat, Latency);
    end
    checks++;
    if (hs !== 1'b1) begin
      errors++;
      $display("FAIL basic_handshake: idle-after-accept=%b, need 1", hs);
    end
  endtask

  task automatic test_rounding();
    int vals [6] = '{14, 15, -14, -15, -4, 0};
    int exps [6] = '{1, 2, -1, -2, 0, 0};
    logic [DW-1:0] d;
    logic [DW-1:0] e;
    logic s;
    logic hs;
    int lat;
    for (int i = 0; i < 6; i++) begin
      e = exps[i][DW-1:0];
      do_op(vals[i], d, s, lat, hs);
      checks++;
      if (d !== e || s !== 1'b0 || lat !== Latency) begin
        errors++;
        $display("FAIL round_%0d: data=%0d sat=%b lat=%0d, need %0d 0 %0d",
                 vals[i], $signed(d), s, lat, exps[i], Latency);
      end
    end
  endtask

  task automatic test_saturation();
    int   vals [4] = '{524287, -524288, 327670, -327680};
    int   exps [4] = '{32767, -32768, 32767, -32768};
    logic sats [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [DW-1:0] d;
    logic [DW-1:0] e;
    logic s;
    logic hs;
    int lat;
    for (int i = 0; i < 4; i++) begin
      e = exps[i][DW-1:0];
      do_op(vals[i], d, s, lat, hs);
      checks++;
      if (d !== e || s !== sats[i]) begin
        errors++;
        $display("FAIL sat_%0d: data=%0d sat=%b, need %0d %b",
                 vals[i], $signed(d), s, exps[i], sats[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d;
    logic s;
    logic hs;
    int lat;
    ready_out = 1'b0;
    do_op(1234, d, s, lat, hs);
    checks++;
    if (d !== 16'd123 || s !== 1'b0 || lat !== Latency) begin
      errors++;
      $display("FAIL bp_result: data=%0d sat=%b lat=%0d, need 123 0 %0d", $signed(d), s, lat,
               Latency);
    end
    for (int i = 0; i < 5; i++) begin
      valid_in = (i % 2 == 0);
      data_in  = 20'd555;
      @(posedge clk); #1;
      checks++;
      if (valid_out !== 1'b1 || data_out !== 16'd123 || sat_out !== 1'b0 || ready_in !== 1'b0)
      begin
        errors++;
        $display("FAIL bp_hold_%0d: valid_out=%b data=%0d sat=%b ready_in=%b, need 1 123 0 0",
                 i, valid_out, $signed(data_out), sat_out, ready_in);
      end
    end
    valid_in  = 1'b0;
    ready_out = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (valid_out !== 1'b0 || ready_in !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid_out=%b ready_in=%b, need 0 1", valid_out, ready_in);
    end
    do_op(555, d, s, lat, hs);
    checks++;
    if (d !== 16'd56 || s !== 1'b0) begin
      errors++;
      $display("FAIL bp_next: data=%0d sat=%b, need 56 0", $signed(d), s);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    logic s;
    logic hs;
    int lat;
    ready_out = 1'b1;
    data_in   = 20'd100;
    valid_in  = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready_in !== 1'b1 || valid_out !== 1'b0 || data_out !== 16'd0 || sat_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: ready_in=%b valid_out=%b data=%h sat=%b, need 1 0 0000 0",
               ready_in, valid_out, data_out, sat_out);
    end
    rst_n = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
    end
    checks++;
    if (valid_out !== 1'b0 || ready_in !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_idle: valid_out=%b ready_in=%b, need 0 1", valid_out, ready_in);
    end
    do_op(37, d, s, lat, hs);
    checks++;
    if (d !== 16'd4 || s !== 1'b0 || lat !== Latency) begin
      errors++;
      $display("FAIL mid_reset_next: data=%0d sat=%b lat=%0d, need 4 0 %0d", $signed(d), s, lat,
               Latency);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    logic [DW-1:0] e;
    logic s;
    logic es;
    logic hs;
    int lat;
    int v;
    logic [IW-1:0] raw;
    ready_out = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (i % 2 == 0) begin
        v = int'($urandom_range(655360)) - 327680;
      end else begin
        raw = IW'($urandom);
        v   = int'($signed(raw));
      end
      model(v, e, es);
      do_op(v, d, s, lat, hs);
      checks++;
      if (d !== e || s !== es || lat !== Latency || hs !== 1'b1) begin
        errors++;
        $display("FAIL rand_%0d in=%0d: data=%0d sat=%b lat=%0d idle=%b, need %0d %b %0d 1",
                 i, v, $signed(d), s, lat, hs, $signed(e), es, Latency);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
